// File: rtl/pep_ks_acc_bank.sv
`default_nettype none
// ============================================================================
// Module  : pep_ks_acc_bank
// Brief   : Per-column accumulation bank behind the key-switch systolic array.
//           Sums level/line partials into PBS slots and queues reduced results.
// Revision: 1.0 - initial release
// ============================================================================
module pep_ks_acc_bank #(
  parameter int CHAN_NB    = 4,
  parameter int OP_W       = 64,
  parameter int MOD_W      = 32,
  parameter int SLOT_NB    = 12,
  parameter int BATCH_ID_W = 2,
  parameter int LVL_MAX    = 8,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           s_rst,
  input  logic [$clog2(LVL_MAX+1)-1:0]   cfg_lvl_nb,
  input  logic [CHAN_NB*OP_W-1:0]        in_data,
  input  logic [CHAN_NB-1:0]             in_avail,
  input  logic [CHAN_NB-1:0]             in_eol,
  input  logic [CHAN_NB-1:0]             in_eoy,
  input  logic [CHAN_NB-1:0]             in_last_iter,
  input  logic [CHAN_NB*BATCH_ID_W-1:0]  in_batch_id,
  output logic [CHAN_NB*MOD_W-1:0]       out_data,
  output logic [CHAN_NB-1:0]             out_last_pbs,
  output logic [CHAN_NB*BATCH_ID_W-1:0]  out_batch_id,
  output logic [CHAN_NB-1:0]             out_vld,
  input  logic [CHAN_NB-1:0]             out_rdy,
  input  logic                           err_clr,
  output logic [CHAN_NB*3-1:0]           error
);

  localparam int LVL_W = $clog2(LVL_MAX+1);
  localparam int PBS_W = (SLOT_NB > 1) ? $clog2(SLOT_NB) : 1;
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = $clog2(OUT_DEPTH+1);
  localparam int ENT_W = MOD_W + 1 + BATCH_ID_W;

  localparam logic [PBS_W-1:0] LAST_SLOT = PBS_W'(SLOT_NB-1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(OUT_DEPTH-1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(OUT_DEPTH);
  localparam logic [LVL_W-1:0] LVL_SAT   = '1;

  for (genvar c = 0; c < CHAN_NB; c++) begin : g_chan
    logic                  avail, eol, eoy, last_iter, eol_beat;
    logic [OP_W-1:0]       data;
    logic [BATCH_ID_W-1:0] bid;

    logic [OP_W-1:0]       op, acc_q, acc_d;
    logic [OP_W-1:0]       slot_q [SLOT_NB];
    logic [OP_W-1:0]       slot_d [SLOT_NB];
    logic [PBS_W-1:0]      pbs_id_q, pbs_id_d, prev_pbs_q, prev_pbs_d;
    logic [BATCH_ID_W-1:0] prev_bid_q, prev_bid_d;
    logic                  prev_avail_q, prev_avail_d;
    logic                  bcol_first_q, bcol_first_d;
    logic [LVL_W-1:0]      lvl_cnt_q, lvl_cnt_d;

    logic                  wr_pend_q, wr_pend_d, wr_last_q, wr_last_d;
    logic                  wr_eoy_q, wr_eoy_d;
    logic [PBS_W-1:0]      wr_pbs_q, wr_pbs_d;
    logic [BATCH_ID_W-1:0] wr_bid_q, wr_bid_d;

    logic [ENT_W-1:0]      fifo_mem_q [OUT_DEPTH];
    logic [ENT_W-1:0]      fifo_mem_d [OUT_DEPTH];
    logic [ENT_W-1:0]      head;
    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  push, push_ok, pop, full, vld;

    logic [2:0]            err_q, err_d, err_new;
    logic                  ovr, lvl_bad;

    assign avail     = in_avail[c];
    assign eol       = in_eol[c];
    assign eoy       = in_eoy[c];
    assign last_iter = in_last_iter[c];
    assign data      = in_data[c*OP_W +: OP_W];
    assign bid       = in_batch_id[c*BATCH_ID_W +: BATCH_ID_W];
    assign eol_beat  = avail & eol;

    always_comb begin
      // Back-to-back beats of the same PBS chain through acc because the
      // slot write of the previous beat has not landed yet.
      op = slot_q[pbs_id_q];
      if (bcol_first_q) begin
        op = '0;
      end else if (prev_avail_q && (prev_pbs_q == pbs_id_q) && (prev_bid_q == bid)) begin
        op = acc_q;
      end
      acc_d = avail ? (op + data) : acc_q;

      pbs_id_d = pbs_id_q;
      ovr      = 1'b0;
      if (eol_beat) begin
        if (eoy) begin
          pbs_id_d = '0;
        end else if (pbs_id_q == LAST_SLOT) begin
          pbs_id_d = '0;
          ovr      = 1'b1;
        end else begin
          pbs_id_d = pbs_id_q + PBS_W'(1);
        end
      end

      bcol_first_d = avail ? (last_iter & eol & eoy) : bcol_first_q;
      prev_avail_d = avail;
      prev_pbs_d   = avail ? pbs_id_q : prev_pbs_q;
      prev_bid_d   = avail ? bid : prev_bid_q;

      if (!avail || eol) begin
        lvl_cnt_d = '0;
      end else if (lvl_cnt_q != LVL_SAT) begin
        lvl_cnt_d = lvl_cnt_q + LVL_W'(1);
      end else begin
        lvl_cnt_d = lvl_cnt_q;
      end
      lvl_bad = eol_beat & (lvl_cnt_q != (cfg_lvl_nb - LVL_W'(1)));

      wr_pend_d = eol_beat;
      wr_last_d = last_iter;
      wr_eoy_d  = eoy;
      wr_pbs_d  = pbs_id_q;
      wr_bid_d  = bid;

      slot_d = slot_q;
      if (wr_pend_q) begin
        slot_d[wr_pbs_q] = wr_last_q ? '0 : acc_q;
      end

      full    = (cnt_q == FULL_CNT);
      vld     = (cnt_q != '0) & ~s_rst;
      pop     = vld & out_rdy[c];
      push    = wr_pend_q & wr_last_q;
      push_ok = push & (~full | pop);

      fifo_mem_d = fifo_mem_q;
      if (push_ok) begin
        fifo_mem_d[wptr_q] = {acc_q[MOD_W-1:0], wr_eoy_q, wr_bid_q};
      end
      wptr_d = wptr_q;
      if (push_ok) begin
        wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
      end
      rptr_d = rptr_q;
      if (pop) begin
        rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);

      err_new = {ovr, lvl_bad, push & full & ~pop};
      err_d   = (err_clr ? 3'b000 : err_q) | err_new;
    end

    always_ff @(posedge clk) begin
      if (s_rst) begin
        acc_q        <= '0;
        slot_q       <= '{default: '0};
        pbs_id_q     <= '0;
        prev_pbs_q   <= '0;
        prev_bid_q   <= '0;
        prev_avail_q <= 1'b0;
        bcol_first_q <= 1'b1;
        lvl_cnt_q    <= '0;
        wr_pend_q    <= 1'b0;
        wr_last_q    <= 1'b0;
        wr_eoy_q     <= 1'b0;
        wr_pbs_q     <= '0;
        wr_bid_q     <= '0;
        fifo_mem_q   <= '{default: '0};
        wptr_q       <= '0;
        rptr_q       <= '0;
        cnt_q        <= '0;
        err_q        <= '0;
      end else begin
        acc_q        <= acc_d;
        slot_q       <= slot_d;
        pbs_id_q     <= pbs_id_d;
        prev_pbs_q   <= prev_pbs_d;
        prev_bid_q   <= prev_bid_d;
        prev_avail_q <= prev_avail_d;
        bcol_first_q <= bcol_first_d;
        lvl_cnt_q    <= lvl_cnt_d;
        wr_pend_q    <= wr_pend_d;
        wr_last_q    <= wr_last_d;
        wr_eoy_q     <= wr_eoy_d;
        wr_pbs_q     <= wr_pbs_d;
        wr_bid_q     <= wr_bid_d;
        fifo_mem_q   <= fifo_mem_d;
        wptr_q       <= wptr_d;
        rptr_q       <= rptr_d;
        cnt_q        <= cnt_d;
        err_q        <= err_d;
      end
    end

    assign head                                    = fifo_mem_q[rptr_q];
    assign out_data[c*MOD_W +: MOD_W]              = head[ENT_W-1 -: MOD_W];
    assign out_last_pbs[c]                         = head[BATCH_ID_W];
    assign out_batch_id[c*BATCH_ID_W +: BATCH_ID_W] = head[BATCH_ID_W-1:0];
    assign out_vld[c]                              = vld;
    assign error[c*3 +: 3]                         = err_q;
  end

endmodule
`default_nettype wire
